// File: rtl/pulse_pkg.sv
// Shared types for the pulse stretcher: FSM state encoding and phase counter width.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } pulse_stretcher_state_t;

    // Wide enough for a load value of 254 (255-cycle phase).
    localparam int PHASE_W = 8;

endpackage

// File: rtl/pulse_stretcher_phase_counter.sv
// Down-counter timing the HIGH and GAP phases; reloads on load_en, holds at zero.
module phase_counter
    import pulse_pkg::*;
#(
    parameter int W = PHASE_W
) (
    input  logic         clk_in,
    input  logic         rst_n_in,
    input  logic         load_en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            cnt_q <= '0;
        end else if (load_en) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches each accepted pulse into a HIGH_CYCLES-wide level followed by a GAP_CYCLES
// low gap, queueing up to QUEUE_DEPTH further requests.
module pulse_stretcher
    import pulse_pkg::*;
#(
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int QUEUE_DEPTH = 7
) (
    input  logic                               clk_in,
    input  logic                               rst_n_in,
    input  logic                               pulse_in,
    input  logic                               clear_in,
    output logic                               level_out,
    output logic                               busy_out,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   pending_out,
    output logic                               overflow_out
);

    localparam int PW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PHASE_W-1:0] HIGH_LOAD = PHASE_W'(HIGH_CYCLES - 1);
    localparam logic [PHASE_W-1:0] GAP_LOAD  = PHASE_W'(GAP_CYCLES - 1);
    localparam logic [PW-1:0]      DEPTH     = PW'(QUEUE_DEPTH);

    pulse_stretcher_state_t state_q, state_d;
    logic [PW-1:0]          pending_q, pending_d;
    logic                   overflow_q, overflow_d;
    logic                   level_q, busy_q;
    logic                   load_en;
    logic [PHASE_W-1:0]     load_val;
    logic                   zero;
    logic                   accept, inc, dec;

    phase_counter #(.W(PHASE_W)) u_phase (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load_en  (load_en),
        .load_val (load_val),
        .zero     (zero)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        load_en    = 1'b0;
        load_val   = '0;
        inc        = 1'b0;
        dec        = 1'b0;
        // A clear in the same cycle discards the request, except as an IDLE start.
        accept     = pulse_in && !clear_in;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = HIGH;
                    load_en  = 1'b1;
                    load_val = HIGH_LOAD;
                end
            end
            HIGH: begin
                inc = accept;
                if (zero) begin
                    state_d  = GAP;
                    load_en  = 1'b1;
                    load_val = GAP_LOAD;
                end
            end
            GAP: begin
                inc = accept;
                if (zero) begin
                    if (pending_q != '0) begin
                        state_d  = HIGH;
                        load_en  = 1'b1;
                        load_val = HIGH_LOAD;
                        dec      = 1'b1;
                    end else if (accept) begin
                        // Empty queue: the request starts the next phase directly.
                        state_d  = HIGH;
                        load_en  = 1'b1;
                        load_val = HIGH_LOAD;
                        inc      = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Simultaneous enqueue and dequeue cancel, so a full queue still accepts.
        if (inc && !dec) begin
            if (pending_q < DEPTH) begin
                pending_d = pending_q + PW'(1);
            end else begin
                overflow_d = 1'b1;
            end
        end else if (dec && !inc) begin
            pending_d = pending_q - PW'(1);
        end

        if (clear_in) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            level_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            level_q    <= (state_d == HIGH);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign level_out    = level_q;
    assign busy_out     = busy_q;
    assign pending_out  = pending_q;
    assign overflow_out = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: directed pulse patterns push expected phases and
// per-cycle snapshots; a monitor pops and compares them as the DUT produces them.
module tb_pulse_stretcher;

    logic       clk_in   = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       pulse_in = 1'b0;
    logic       clear_in = 1'b0;
    logic       level_out;
    logic       busy_out;
    logic [2:0] pending_out;
    logic       overflow_out;

    pulse_stretcher #(
        .HIGH_CYCLES (4),
        .GAP_CYCLES  (2),
        .QUEUE_DEPTH (7)
    ) dut (
        .clk_in       (clk_in),
        .rst_n_in     (rst_n_in),
        .pulse_in     (pulse_in),
        .clear_in     (clear_in),
        .level_out    (level_out),
        .busy_out     (busy_out),
        .pending_out  (pending_out),
        .overflow_out (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    int gcyc = 0;
    always @(posedge clk_in) gcyc <= gcyc + 1;

    typedef struct {
        int   cyc;
        logic lvl;
        logic busy;
        int   pend;
        logic ovf;
    } pt_t;

    typedef struct {
        int start;
        int len;
    } ph_t;

    pt_t  pt_q[$];
    ph_t  ph_q[$];
    int   checks = 0;
    int   errors = 0;
    int   base   = 0;
    logic [127:0] pm, cm, rm;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, gcyc);
        end
    endtask

    task automatic pt(input int rel, input logic l, input logic b, input int p, input logic o);
        pt_q.push_back('{base + rel, l, b, p, o});
    endtask

    task automatic ph(input int rel, input int len);
        ph_q.push_back('{base + rel, len});
    endtask

    task automatic do_reset();
        rst_n_in = 1'b0;
        pulse_in = 1'b0;
        clear_in = 1'b0;
        @(negedge clk_in);
        base = gcyc;
        pt(0, 1'b0, 1'b0, 0, 1'b0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        base = gcyc;
    endtask

    task automatic run(input logic [127:0] p, input logic [127:0] c, input logic [127:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            pulse_in = p[i];
            clear_in = c[i];
            rst_n_in = ~r[i];
            @(negedge clk_in);
        end
        pulse_in = 1'b0;
        clear_in = 1'b0;
        rst_n_in = 1'b1;
    endtask

    // Monitor: samples just after the falling edge, away from the active edge.
    logic prev_lvl = 1'b0;
    int   ph_start = 0;
    initial begin
        pt_t p;
        ph_t h;
        forever begin
            @(negedge clk_in);
            #1;
            while (pt_q.size() > 0 && pt_q[0].cyc <= gcyc) begin
                p = pt_q.pop_front();
                check("level_out", level_out, p.lvl);
                check("busy_out", busy_out, p.busy);
                check("pending_out", pending_out, p.pend);
                check("overflow_out", overflow_out, p.ovf);
            end
            if (level_out === 1'b1 && !prev_lvl) ph_start = gcyc;
            if (level_out !== 1'b1 && prev_lvl) begin
                if (ph_q.size() == 0) begin
                    check("unexpected_phase_start", ph_start, -1);
                end else begin
                    h = ph_q.pop_front();
                    check("phase_start", ph_start, h.start);
                    check("phase_len", gcyc - ph_start, h.len);
                end
            end
            prev_lvl = (level_out === 1'b1);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at cycle %0d", gcyc);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk_in);

        // Single pulse.
        do_reset();
        ph(1, 4);
        pt(1, 1, 1, 0, 0);
        pt(5, 0, 1, 0, 0);
        pt(7, 0, 0, 0, 0);
        run(128'h1, '0, '0, 10);

        // Three back-to-back pulses.
        do_reset();
        ph(1, 4); ph(7, 4); ph(13, 4);
        pt(3, 1, 1, 2, 0);
        pt(7, 1, 1, 1, 0);
        pt(13, 1, 1, 0, 0);
        pt(19, 0, 0, 0, 0);
        run(128'h7, '0, '0, 22);

        // Ten pulses: saturation, overflow, sticky flag.
        do_reset();
        for (int k = 0; k < 9; k++) ph(1 + 6 * k, 4);
        pt(9, 1, 1, 7, 0);
        pt(10, 1, 1, 7, 1);
        pt(13, 1, 1, 6, 1);
        pt(55, 0, 0, 0, 1);
        run(128'h3FF, '0, '0, 60);

        // Pulse in the last GAP cycle with an empty queue.
        do_reset();
        ph(1, 4); ph(7, 4);
        pt(6, 0, 1, 0, 0);
        pt(7, 1, 1, 0, 0);
        pt(11, 0, 1, 0, 0);
        pt(13, 0, 0, 0, 0);
        pm = '0; pm[0] = 1'b1; pm[6] = 1'b1;
        run(pm, '0, '0, 16);

        // Reset mid-HIGH with a non-empty queue, then a pulse right after release.
        do_reset();
        ph(1, 3); ph(5, 4);
        pt(3, 1, 1, 2, 0);
        pt(4, 0, 0, 0, 0);
        pt(9, 0, 1, 0, 0);
        pt(11, 0, 0, 0, 0);
        rm = '0; rm[3] = 1'b1;
        run(128'h1F, '0, rm, 14);

        // Full queue accepts a pulse in the last GAP cycle without overflow.
        do_reset();
        for (int k = 0; k < 10; k++) ph(1 + 6 * k, 4);
        pt(9, 1, 1, 7, 0);
        pt(12, 0, 1, 7, 0);
        pt(13, 1, 1, 7, 0);
        pt(61, 0, 0, 0, 0);
        pm = '0; pm[8:0] = '1; pm[12] = 1'b1;
        run(pm, '0, '0, 64);

        // Clear together with a pulse: starts from IDLE, discarded while busy.
        do_reset();
        ph(1, 4);
        pt(2, 1, 1, 1, 0);
        pt(3, 1, 1, 0, 0);
        pt(7, 0, 0, 0, 0);
        cm = '0; cm[0] = 1'b1; cm[2] = 1'b1;
        run(128'h7, cm, '0, 10);

        // Clear with overflow set: queue and flag drop, running phase completes.
        do_reset();
        ph(1, 4); ph(7, 4); ph(13, 4);
        pt(12, 0, 1, 7, 1);
        pt(13, 1, 1, 0, 0);
        pt(17, 0, 1, 0, 0);
        pt(19, 0, 0, 0, 0);
        cm = '0; cm[12] = 1'b1;
        run(128'h3FF, cm, '0, 22);

        repeat (3) @(negedge clk_in);
        #2;
        check("points_left", pt_q.size(), 0);
        check("phases_left", ph_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
